// File: rtl/banked_strb_memory.sv
// banked_strb_memory: word memory with byte strobes, a 2-entry read
// response FIFO and optional zero-fill of the array after reset.
// Ports: clk_i, rst_ni (sync, active-low); req_valid_i/req_ready_o,
// req_addr_i, req_we_i, req_strb_i, req_wdata_i (request channel);
// rsp_valid_o/rsp_ready_i, rsp_rdata_o (read response channel);
// init_done_o (array initialised, block operational).
module banked_strb_memory #(
  parameter int DataWidth = 128,
  parameter int DataDepth = 64,
  parameter int AddrWidth =
    (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter bit ClearOnReset = 1'b1,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic                        req_we_i,
  input  logic [StrbWidth-1:0]        req_strb_i,
  input  logic signed [DataWidth-1:0] req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic signed [DataWidth-1:0] rsp_rdata_o,
  output logic                        init_done_o
);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic                 active;
  logic [AddrWidth-1:0] init_cnt;
  logic [DataWidth-1:0] mem [DataDepth];
  logic [DataWidth-1:0] fifo [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic                 req_fire;
  logic                 rsp_fire;
  logic                 push;
  logic                 in_range;
  logic                 init_last;
  logic [DataWidth-1:0] rd_word;

  // active keeps ready/done low on the reset edge itself, even when
  // the FSM restarts directly in RUN.
  assign req_ready_o = active && (state == RUN) && (count != 2'd2);
  assign init_done_o = active && (state == RUN);
  assign rsp_valid_o = (count != 2'd0);
  assign rsp_rdata_o = fifo[rd_ptr];

  assign req_fire = req_valid_i && req_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;
  assign push     = req_fire && !req_we_i;

  assign in_range  = 32'(req_addr_i) < 32'(DataDepth);
  assign init_last = 32'(init_cnt) == 32'(DataDepth - 1);
  assign rd_word   = in_range ? mem[req_addr_i] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ClearOnReset ? INIT : RUN;
      active   <= 1'b0;
      init_cnt <= '0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      active <= 1'b1;
      if (state == INIT) begin
        init_cnt <= init_cnt + AddrWidth'(1);
        if (init_last) state <= RUN;
      end
      if (push) begin
        fifo[wr_ptr] <= rd_word;
        wr_ptr       <= ~wr_ptr;
      end
      if (rsp_fire) rd_ptr <= ~rd_ptr;
      unique case ({push, rsp_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Array has no reset of its own; INIT zero-fills it one word a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state == INIT) begin
        mem[init_cnt] <= '0;
      end else if (req_fire && req_we_i && in_range) begin
        for (int b = 0; b < StrbWidth; b++) begin
          if (req_strb_i[b]) begin
            mem[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_strb_memory.sv
// tb_banked_strb_memory: table-driven and scoreboard checks of
// banked_strb_memory (depth 16, depth 12, and no-clear variants).
module tb_banked_strb_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready, we, rsp_valid, rsp_ready, done;
  logic [3:0]  addr, strb;
  logic [31:0] wdata, rdata;

  logic        b_valid, b_ready, b_we, b_rsp_valid, b_done;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;

  logic        c_ready, c_rsp_valid, c_done;
  logic [31:0] c_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];
  logic [31:0] mon_exp;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  banked_strb_memory #(
    .DataWidth(32), .DataDepth(16), .ClearOnReset(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr), .req_we_i(we),
    .req_strb_i(strb), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rdata), .init_done_o(done)
  );

  banked_strb_memory #(
    .DataWidth(32), .DataDepth(12), .ClearOnReset(1'b1)
  ) u_d12 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_addr_i(b_addr), .req_we_i(b_we),
    .req_strb_i(4'hF), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(b_rdata), .init_done_o(b_done)
  );

  banked_strb_memory #(
    .DataWidth(32), .DataDepth(16), .ClearOnReset(1'b0)
  ) u_nc (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(1'b0), .req_ready_o(c_ready),
    .req_addr_i(4'd0), .req_we_i(1'b0),
    .req_strb_i(4'h0), .req_wdata_i(32'd0),
    .rsp_valid_o(c_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(c_rdata), .init_done_o(c_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop side. Samples at negedge what the next edge pops.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale_rsp: got %h want none", rdata);
      end else begin
        mon_exp = q.pop_front();
        chk("rsp_data", rdata, mon_exp);
      end
    end
  end

  // Drive a request; returns at the negedge before its acceptance
  // edge, with valid still high so calls chain back-to-back.
  task automatic issue(input logic w, input logic [3:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] e, output int waits);
    waits = 0;
    @(posedge clk); #1;
    valid = 1'b1; we = w; addr = a; strb = s; wdata = d;
    @(negedge clk);
    while (!ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: ready=%0b want 1", ready);
    end else if (!w) begin
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic wait_init(input string nm, input int k0);
    int k = k0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, k, 16);
  endtask

  task automatic b_op(input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] e);
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = w; b_addr = a; b_wdata = d;
    @(negedge clk);
    chk("d12_ready", b_ready, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    if (!w) begin
      chk("d12_rvalid", b_rsp_valid, 1);
      chk("d12_rdata", b_rdata, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t want finish", $time);
    $fatal(1);
  end

  initial begin
    int w;
    logic [3:0]  aa[4];
    logic [31:0] ee[4];

    tbl[0]  = '{1'b1, 4'd3,  4'hF, 32'hAABBCCDD, 32'h0};
    tbl[1]  = '{1'b1, 4'd3,  4'h5, 32'h11223344, 32'h0};
    tbl[2]  = '{1'b0, 4'd3,  4'h0, 32'h0, 32'hAA22CC44};
    tbl[3]  = '{1'b1, 4'd5,  4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[4]  = '{1'b0, 4'd5,  4'h0, 32'h0, 32'h00000000};
    tbl[5]  = '{1'b1, 4'd7,  4'hF, 32'h12345678, 32'h0};
    tbl[6]  = '{1'b0, 4'd7,  4'h0, 32'h0, 32'h12345678};
    tbl[7]  = '{1'b1, 4'd7,  4'h8, 32'h9A000000, 32'h0};
    tbl[8]  = '{1'b0, 4'd7,  4'h0, 32'h0, 32'h9A345678};
    tbl[9]  = '{1'b1, 4'd0,  4'h3, 32'h0000BEEF, 32'h0};
    tbl[10] = '{1'b0, 4'd0,  4'h0, 32'h0, 32'h0000BEEF};
    tbl[11] = '{1'b1, 4'd15, 4'hF, 32'h80000001, 32'h0};
    tbl[12] = '{1'b0, 4'd15, 4'h0, 32'h0, 32'h80000001};
    tbl[13] = '{1'b0, 4'd3,  4'h0, 32'h0, 32'hAA22CC44};

    rst_n = 1'b0; valid = 1'b0; we = 1'b0; addr = '0;
    strb = '0; wdata = '0; rsp_ready = 1'b1;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_nc_ready", c_ready, 0);
    chk("rst_nc_done", c_done, 0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("nc_ready", c_ready, 1);
    chk("nc_done", c_done, 1);
    chk("init_ready", ready, 0);
    wait_init("init_cycles", 1);

    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'(i), 4'h0, 32'h0, 32'h0, w);
    end
    idle();
    drain();

    // Depth-12 instance: out-of-range accesses.
    begin
      int n = 0;
      while (!b_done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("d12_done", b_done, 1);
    end
    b_op(1'b1, 4'd11, 32'h00000077, 32'h0);
    b_op(1'b1, 4'd13, 32'h00000005, 32'h0);
    b_op(1'b0, 4'd13, 32'h0, 32'h00000000);
    b_op(1'b0, 4'd11, 32'h0, 32'h00000077);
    b_op(1'b0, 4'd1,  32'h0, 32'h00000000);

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].we, tbl[i].addr, tbl[i].strb,
            tbl[i].wdata, tbl[i].exp, w);
    end
    idle();
    drain();

    // Read latency is one cycle.
    issue(1'b0, 4'd3, 4'h0, 32'h0, 32'hAA22CC44, w);
    chk("lat_pre_valid", rsp_valid, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("lat_valid", rsp_valid, 1);
    chk("lat_data", rdata, 32'hAA22CC44);
    drain();

    // Backpressure: two reads fill the FIFO, third stalls.
    issue(1'b1, 4'd1, 4'hF, 32'h01010101, 32'h0, w);
    issue(1'b1, 4'd2, 4'hF, 32'h02020202, 32'h0, w);
    idle();
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 4'h0, 32'h0, 32'h01010101, w);
    issue(1'b0, 4'd2, 4'h0, 32'h0, 32'h02020202, w);
    @(posedge clk); #1;
    addr = 4'd3;
    chk("stall_ready", ready, 0);
    chk("stall_rvalid", rsp_valid, 1);
    chk("stall_data", rdata, 32'h01010101);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_hold", rdata, 32'h01010101);
      chk("stall_block", ready, 0);
    end
    rsp_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("stall_release", ready, 1);
      if (ready) q.push_back(32'hAA22CC44);
    end
    idle();
    drain();

    // Back-to-back reads hold the FIFO at count 1.
    aa[0] = 4'd3;  ee[0] = 32'hAA22CC44;
    aa[1] = 4'd7;  ee[1] = 32'h9A345678;
    aa[2] = 4'd0;  ee[2] = 32'h0000BEEF;
    aa[3] = 4'd15; ee[3] = 32'h80000001;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, aa[i%4], 4'h0, 32'h0, ee[i%4], w);
      if (i > 0) begin
        chk("b2b_wait", w, 0);
        chk("b2b_count1", {ready, rsp_valid}, 2'b11);
      end
    end
    idle();
    drain();

    // Reset with two responses pending.
    rsp_ready = 1'b0;
    issue(1'b0, 4'd7, 4'h0, 32'h0, 32'h9A345678, w);
    issue(1'b0, 4'd0, 4'h0, 32'h0, 32'h0000BEEF, w);
    idle();
    chk("pend_full", ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    chk("rr_rvalid", rsp_valid, 0);
    chk("rr_ready", ready, 0);
    chk("rr_done", done, 0);
    rsp_ready = 1'b1;
    wait_init("reinit_cycles", 0);
    issue(1'b0, 4'd7, 4'h0, 32'h0, 32'h0, w);
    issue(1'b0, 4'd3, 4'h0, 32'h0, 32'h0, w);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_strb_memory.md
BANKED_STRB_MEMORY -- requirements
Module: banked_strb_memory

Interface
REQ-001 SHALL have parameter DataWidth, default 128, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DataDepth, default 64, number of words.
REQ-003 SHALL have parameter AddrWidth, default (DataDepth<=1)?1:$clog2(DataDepth), address width.
REQ-004 SHALL have parameter ClearOnReset, default 1, zero-fill the whole array after reset when 1.
REQ-005 SHALL have derived StrbWidth = DataWidth/8.
REQ-006 clk_i  input  1  single clock, all state updates on rising edge.
REQ-007 rst_ni  input  1  reset, synchronous, active-low.
REQ-008 req_valid_i  input  1  request present.
REQ-009 req_ready_o  output  1  request can be accepted.
REQ-010 req_addr_i  input  AddrWidth  word address.
REQ-011 req_we_i  input  1  1 = write, 0 = read.
REQ-012 req_strb_i  input  StrbWidth  byte write enables, bit i covers bits [8i+7:8i].
REQ-013 req_wdata_i  input  DataWidth signed  write data.
REQ-014 rsp_valid_o  output  1  read data present.
REQ-015 rsp_ready_i  input  1  consumer accepts read data.
REQ-016 rsp_rdata_o  output  DataWidth signed  read data.
REQ-017 init_done_o  output  1  array initialisation finished, block operational.

Function
REQ-018 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT when ClearOnReset=1, otherwise RUN.
REQ-019 In INIT, SHALL write zero to addresses 0..DataDepth-1, one address per cycle in ascending order, then enter RUN on the cycle after writing DataDepth-1; INIT lasts exactly DataDepth cycles.
REQ-020 In INIT, req_ready_o=0 and init_done_o=0; in RUN, init_done_o=1.
REQ-021 A request SHALL be accepted on a rising edge where req_valid_i=1 and req_ready_o=1; address, we, strb and wdata are sampled only then.
REQ-022 An accepted write SHALL update only the bytes whose req_strb_i bit is 1; strb=0 leaves the word unchanged; writes produce no response.
REQ-023 An accepted read SHALL push the addressed word into a 2-entry response FIFO at the acceptance edge; rsp_valid_o rises the following cycle (latency 1).
REQ-024 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 req_ready_o SHALL be 1 only in RUN with response FIFO count < 2, and SHALL NOT depend combinationally on rsp_ready_i or req_valid_i; a full FIFO blocks both reads and writes.
REQ-026 rsp_valid_o=1 iff FIFO count>0; rsp_rdata_o = FIFO head; a pop occurs on a rising edge with rsp_valid_o=1 and rsp_ready_i=1.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; responses return strictly in request order.
REQ-028 While rsp_valid_o=1 and rsp_ready_i=0, rsp_rdata_o SHALL hold stable.
REQ-029 An address >= DataDepth SHALL be accepted normally: a write is ignored, and a read returns all-zero data.
REQ-030 The FIFO read and write pointers SHALL be 1 bit each and wrap modulo 2.

Reset
REQ-031 When rst_ni=0 on a rising edge: FIFO count=0, pointers=0, rsp_valid_o=0, req_ready_o=0, init_done_o=0, and the INIT counter=0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL discard all pending responses and restart per REQ-018; the array is not cleared during reset itself.
REQ-033 With ClearOnReset=0, req_ready_o=1 and init_done_o=1 from the first cycle after reset release; array contents are unchanged by reset.

Verification (DataWidth=32, DataDepth=16 unless stated)
REQ-034 Release reset with ClearOnReset=1 -> init_done_o rises after exactly 16 cycles; a read of each address 0..15 returns 0x00000000.
REQ-035 Write 0xAABBCCDD to addr 3 with strb=1111, then write 0x11223344 with strb=0101, then read addr 3 -> 0xAA22CC44 one cycle after acceptance.
REQ-036 Hold rsp_ready_i=0 and issue reads of addrs 1, 2, 3 -> two are accepted, req_ready_o=0, the third is stalled; raise rsp_ready_i -> data returned in order 1, 2, 3 and rsp_rdata_o is stable while stalled.
REQ-037 Hold the FIFO at count 1 with back-to-back reads and rsp_ready_i=1 -> one read is accepted per cycle and count stays 1.
REQ-038 Set DataDepth=12, write 0x5 to addr 13, then read addr 13 -> read returns 0x00000000 and the array is unchanged.
REQ-039 Assert rst_ni=0 for one cycle with 2 responses pending -> rsp_valid_o=0 the next cycle, INIT reruns, and no stale response appears.
